// File: rtl/lzc_norm_pipe.sv
// rtl/lzc_norm_pipe.sv - two-stage leading-digit counter and normaliser with valid/ready handshake
// S1 registers per-byte partial counts; S2 merges them, shifts, and registers the result.
module lzc_norm_pipe #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_ones,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_cnt,
  output logic [WIDTH-1:0] out_norm,
  output logic             out_all,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NG = WIDTH / 8;

  logic                 advance;
  logic [WIDTH-1:0]     inv;
  logic [NG-1:0][3:0]   g_cnt;
  logic [NG-1:0]        g_all;

  logic                 s1_valid;
  logic [WIDTH-1:0]     s1_data;
  logic [TAG_W-1:0]     s1_tag;
  logic [NG-1:0][3:0]   s1_pcnt;
  logic [NG-1:0]        s1_pall;

  logic [CNT_W-1:0]     cnt;
  logic                 stop;
  logic [WIDTH-1:0]     norm;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;

  // Ones mode counts leading zeros of the inverted word; the shift uses the original data.
  assign inv = in_data ^ {WIDTH{in_ones}};

  always_comb begin
    g_cnt = '0;
    g_all = '0;
    for (int g = 0; g < NG; g++) begin
      g_cnt[g] = 4'd8;
      g_all[g] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (inv[g*8+i]) begin
          g_cnt[g] = 4'(7 - i);
          g_all[g] = 1'b0;
        end
      end
    end
  end

  // Accumulate byte counts from the MSB group down until the first group holding the other digit.
  always_comb begin
    cnt  = '0;
    stop = 1'b0;
    for (int g = NG - 1; g >= 0; g--) begin
      if (!stop) cnt = cnt + CNT_W'(s1_pcnt[g]);
      if (!s1_pall[g]) stop = 1'b1;
    end
  end

  assign norm = s1_data << cnt;

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_data <= in_data;
      s1_tag  <= in_tag;
      s1_pcnt <= g_cnt;
      s1_pall <= g_all;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_cnt   <= '0;
      out_norm  <= '0;
      out_all   <= 1'b0;
      out_tag   <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      out_cnt   <= cnt;
      out_norm  <= norm;
      out_all   <= (cnt == CNT_W'(WIDTH));
      out_tag   <= s1_tag;
    end
  end

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// tb/tb_lzc_norm_pipe.sv - directed and randomized bench for lzc_norm_pipe at WIDTH 64 and 16
module tb_lzc_norm_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, in_valid, in_ones, out_ready;
  logic [63:0] in_data;
  logic [7:0]  in_tag;

  logic        r64, v64, a64;
  logic [6:0]  c64;
  logic [63:0] n64;
  logic [7:0]  t64;
  logic        r16, v16, a16;
  logic [4:0]  c16;
  logic [15:0] n16;
  logic [0:0]  t16;

  lzc_norm_pipe #(.WIDTH(64), .TAG_W(8)) u64 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(r64),
    .in_data(in_data), .in_ones(in_ones), .in_tag(in_tag),
    .out_valid(v64), .out_ready(out_ready), .out_cnt(c64), .out_norm(n64),
    .out_all(a64), .out_tag(t64)
  );

  lzc_norm_pipe #(.WIDTH(16), .TAG_W(1)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(r16),
    .in_data(in_data[15:0]), .in_ones(in_ones), .in_tag(in_tag[0:0]),
    .out_valid(v16), .out_ready(out_ready), .out_cnt(c16), .out_norm(n16),
    .out_all(a16), .out_tag(t16)
  );

  logic        o_rdy, o_vld, o_all;
  logic [7:0]  o_cnt, o_tag;
  logic [63:0] o_norm;
  assign o_rdy  = sel ? r16 : r64;
  assign o_vld  = sel ? v16 : v64;
  assign o_all  = sel ? a16 : a64;
  assign o_cnt  = sel ? {3'b0, c16} : {1'b0, c64};
  assign o_tag  = sel ? {7'b0, t16} : t64;
  assign o_norm = sel ? {48'b0, n16} : n64;

  typedef struct {
    logic [63:0] d;
    logic        o;
    logic [7:0]  t;
  } ent_t;

  ent_t        q[$];
  int          passed = 0, total = 0, n_acc = 0;
  bit          m_s1 = 1'b0, m_out = 1'b0, stl = 1'b0;
  logic [7:0]  s_cnt, s_tag;
  logic [63:0] s_norm;
  logic        s_all;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", name, obs, exp);
  endtask

  // Leading-digit count straight from the definition: walk down from the MSB.
  function automatic int lead(input logic [63:0] d, input logic o, input int w);
    int n = 0;
    for (int i = w - 1; i >= 0; i--) begin
      if (d[i] !== o) break;
      n++;
    end
    return n;
  endfunction

  task automatic cycle(input logic v, input logic [63:0] d, input logic o,
                       input logic [7:0] t, input logic r, input logic rs);
    ent_t        e;
    int          n, w;
    logic [63:0] en;
    bit          adv, acc;
    w = sel ? 16 : 64;
    rst = rs; in_valid = v; in_data = d; in_ones = o; in_tag = t; out_ready = r;
    #1;
    adv = !m_out || r;
    acc = v && adv && !rs;
    chk("in_ready", 64'(o_rdy), 64'(adv && !rs));
    chk("out_valid", 64'(o_vld), 64'(m_out));
    if (stl) begin
      chk("stall_cnt", 64'(o_cnt), 64'(s_cnt));
      chk("stall_norm", o_norm, s_norm);
      chk("stall_all", 64'(o_all), 64'(s_all));
      chk("stall_tag", 64'(o_tag), 64'(s_tag));
    end
    if (m_out && r && !rs && q.size() > 0) begin
      e  = q.pop_front();
      n  = lead(e.d, e.o, w);
      en = e.d << n;
      if (sel) en[63:16] = '0;
      chk("cnt", 64'(o_cnt), 64'(n));
      chk("norm", o_norm, en);
      chk("all", 64'(o_all), 64'(n == w));
      chk("tag", 64'(o_tag), 64'(e.t));
    end
    s_cnt = o_cnt; s_norm = o_norm; s_all = o_all; s_tag = o_tag;
    stl = m_out && !r && !rs;
    if (acc) begin
      e.d = sel ? {48'b0, d[15:0]} : d;
      e.o = o;
      e.t = sel ? {7'b0, t[0]} : t;
      q.push_back(e);
      n_acc++;
    end
    if (rs) begin
      m_s1 = 1'b0; m_out = 1'b0; q.delete();
    end else if (adv) begin
      m_out = m_s1; m_s1 = acc;
    end
    @(negedge clk);
  endtask

  logic [63:0] vec [5];
  logic        vones [5];
  int          idx, base, k;
  logic [63:0] d;
  logic        o;

  initial begin
    sel = 1'b0; rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ones = 1'b0;
    in_tag = '0; out_ready = 1'b1;
    @(negedge clk);
    cycle(0, 64'h0, 0, 8'h0, 1, 1);
    cycle(0, 64'h0, 0, 8'h0, 1, 1);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_valid", 64'(o_vld), 64'h0);
      chk("rst_cnt", 64'(o_cnt), 64'h0);
      chk("rst_norm", o_norm, 64'h0);
      chk("rst_all", 64'(o_all), 64'h0);
      chk("rst_tag", 64'(o_tag), 64'h0);
      chk("rst_ready", 64'(o_rdy), 64'h0);
    end
    sel = 1'b0;
    @(negedge clk);

    cycle(1, 64'h02FF_FFFF_FFFF_FFFF, 0, 8'h5A, 1, 0);
    cycle(0, 64'h0, 0, 8'h0, 1, 0);
    chk("ex_valid", 64'(o_vld), 64'h1);
    chk("ex_cnt", 64'(o_cnt), 64'd6);
    chk("ex_norm", o_norm, 64'hBFFF_FFFF_FFFF_FFC0);
    chk("ex_all", 64'(o_all), 64'h0);
    chk("ex_tag", 64'(o_tag), 64'h5A);
    cycle(0, 64'h0, 0, 8'h0, 1, 0);

    vec   = '{64'h0, 64'h8000_0000_0000_0001, 64'h1, 64'hFFF0_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    vones = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      cycle(1, vec[i], vones[i], 8'(i + 16), 1, 0);
      cycle(0, 64'h0, 0, 8'h0, 1, 0);
      cycle(0, 64'h0, 0, 8'h0, 1, 0);
    end

    idx = 0;
    for (int c = 0; c < 40 && (idx < 10 || q.size() > 0); c++) begin
      base = n_acc;
      d = 64'hFFFF_FFFF_FFFF_FFFF >> (idx * 7);
      if (idx[0]) d = ~d;
      cycle(idx < 10, d, idx[0], 8'(idx), !(c >= 4 && c < 9), 0);
      if (n_acc > base) idx++;
    end
    chk("stream_words", 64'(idx), 64'd10);
    chk("stream_drain", 64'(q.size()), 64'h0);

    cycle(1, 64'h0000_00FF_0000_0000, 0, 8'hA1, 0, 0);
    cycle(1, 64'h0F00_0000_0000_0000, 0, 8'hA2, 0, 0);
    cycle(1, 64'h1234_0000_0000_0000, 0, 8'hA3, 0, 1);
    chk("mid_rst_cnt", 64'(o_cnt), 64'h0);
    chk("mid_rst_norm", o_norm, 64'h0);
    chk("mid_rst_tag", 64'(o_tag), 64'h0);
    cycle(1, 64'h0000_0000_0001_0000, 0, 8'hA4, 1, 0);
    for (int c = 0; c < 4; c++) cycle(0, 64'h0, 0, 8'h0, 1, 0);
    chk("rst_drain", 64'(q.size()), 64'h0);

    sel = 1'b1;
    base = n_acc;
    for (int c = 0; c < 6000 && n_acc - base < 1000; c++) begin
      k = $urandom_range(0, 7);
      o = 1'($urandom);
      if (k == 0)      d = 64'h0;
      else if (k == 1) d = 64'hFFFF;
      else begin
        d = 64'(($urandom & 32'hFFFF) >> $urandom_range(0, 15));
        if (o) d = d ^ 64'hFFFF;
      end
      cycle($urandom_range(0, 3) != 0, d, o, 8'($urandom), $urandom_range(0, 3) != 0, 0);
    end
    for (int c = 0; c < 10; c++) cycle(0, 64'h0, 0, 8'h0, 1, 0);
    chk("rand_words", 64'(n_acc - base), 64'd1000);
    chk("rand_drain", 64'(q.size()), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
